// File: rtl/sync_dual_port_ram_if.sv
`default_nettype none
// ============================================================================
// Module   : sync_dual_port_ram_if
// Brief    : Write-port, read-port and status bundle for sync_dual_port_ram.
// Revision : 1.0 - initial release
// ============================================================================
interface sync_dual_port_ram_if #(
    parameter int ADDR_SIZE = 10,
    parameter int DATA_SIZE = 8
);
    logic                 wr_cs;
    logic                 we;
    logic [ADDR_SIZE-1:0] wr_addr;
    logic [DATA_SIZE-1:0] d_in;
    logic                 rd_cs;
    logic                 re;
    logic [ADDR_SIZE-1:0] rd_addr;
    logic [DATA_SIZE-1:0] d_out;
    logic                 d_valid;
    logic                 busy;
    logic                 addr_err;

    modport master (
        output wr_cs, we, wr_addr, d_in, rd_cs, re, rd_addr,
        input  d_out, d_valid, busy, addr_err
    );

    modport slave (
        input  wr_cs, we, wr_addr, d_in, rd_cs, re, rd_addr,
        output d_out, d_valid, busy, addr_err
    );
endinterface
`default_nettype wire

// File: rtl/sync_dual_port_ram.sv
`default_nettype none
// ============================================================================
// Module   : sync_dual_port_ram
// Brief    : Simple dual-port RAM, registered read, selectable read-during-write,
//            address range check and a post-reset clear sequencer.
// Revision : 1.0 - initial release
// ============================================================================
module sync_dual_port_ram #(
    parameter int                   ADDR_SIZE = 10,
    parameter int                   DATA_SIZE = 8,
    parameter int                   MEM_SIZE  = 1024,
    parameter int                   RDW_MODE  = 0,
    parameter logic [DATA_SIZE-1:0] CLEAR_VAL = '0
) (
    input wire clk,
    input wire rst,
    sync_dual_port_ram_if.slave bus
);

    localparam int                 c_idx_w    = (MEM_SIZE > 1) ? $clog2(MEM_SIZE) : 1;
    localparam logic [c_idx_w-1:0] c_last     = c_idx_w'(MEM_SIZE - 1);
    localparam logic [ADDR_SIZE:0] c_mem_size = (ADDR_SIZE + 1)'(MEM_SIZE);

    localparam logic [0:0] c_st_clear = 1'b0;
    localparam logic [0:0] c_st_ready = 1'b1;

    logic [0:0]           r_state;
    logic [0:0]           w_state_next;
    logic [c_idx_w-1:0]   r_clr_cnt;
    logic [DATA_SIZE-1:0] r_mem [0:MEM_SIZE-1];
    logic [DATA_SIZE-1:0] r_d_out;
    logic                 r_d_valid;
    logic                 r_addr_err;

    logic                 w_busy;
    logic                 w_wr_acc;
    logic                 w_rd_acc;
    logic                 w_wr_oor;
    logic                 w_rd_oor;
    logic                 w_collide;
    logic                 w_mem_we;
    logic [c_idx_w-1:0]   w_mem_idx;
    logic [DATA_SIZE-1:0] w_mem_wdata;
    logic [c_idx_w-1:0]   w_wr_idx;
    logic [c_idx_w-1:0]   w_rd_idx;
    logic [DATA_SIZE-1:0] w_rd_old;
    logic [DATA_SIZE-1:0] w_rd_data;

    assign w_wr_idx  = bus.wr_addr[c_idx_w-1:0];
    assign w_rd_idx  = bus.rd_addr[c_idx_w-1:0];
    assign w_wr_oor  = ({1'b0, bus.wr_addr} >= c_mem_size);
    assign w_rd_oor  = ({1'b0, bus.rd_addr} >= c_mem_size);
    assign w_collide = w_wr_acc & ~w_wr_oor & (bus.wr_addr == bus.rd_addr);
    assign w_rd_old  = r_mem[w_rd_idx];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_st_clear;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_st_clear: if (r_clr_cnt == c_last) w_state_next = c_st_ready;
            c_st_ready: w_state_next = c_st_ready;
            default:    w_state_next = c_st_clear;
        endcase
    end

    // While rst is held the state is CLEAR; masking with rst keeps the
    // sequencer from overwriting location 0 on every held-reset edge.
    always_comb begin
        w_busy      = (r_state == c_st_clear);
        w_wr_acc    = bus.wr_cs & bus.we & ~w_busy;
        w_rd_acc    = bus.rd_cs & bus.re & ~w_busy;
        w_mem_we    = 1'b0;
        w_mem_idx   = r_clr_cnt;
        w_mem_wdata = CLEAR_VAL;
        if (w_busy) begin
            w_mem_we = ~rst;
        end else begin
            w_mem_we    = w_wr_acc & ~w_wr_oor & ~rst;
            w_mem_idx   = w_wr_idx;
            w_mem_wdata = bus.d_in;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_clr_cnt <= '0;
        end else if (w_busy) begin
            r_clr_cnt <= r_clr_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            r_mem[w_mem_idx] <= w_mem_wdata;
        end
    end

    generate
        if (RDW_MODE == 1) begin : g_rdw_new
            assign w_rd_data = w_collide ? bus.d_in : w_rd_old;
        end else begin : g_rdw_old
            assign w_rd_data = w_rd_old;
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_d_out    <= '0;
            r_d_valid  <= 1'b0;
            r_addr_err <= 1'b0;
        end else begin
            r_d_valid  <= w_rd_acc;
            r_addr_err <= (w_wr_acc & w_wr_oor) | (w_rd_acc & w_rd_oor);
            if (w_rd_acc) begin
                r_d_out <= w_rd_oor ? '0 : w_rd_data;
            end
        end
    end

    assign bus.d_out    = r_d_out;
    assign bus.d_valid  = r_d_valid;
    assign bus.addr_err = r_addr_err;
    assign bus.busy     = w_busy;

endmodule
`default_nettype wire

// File: tb/tb_sync_dual_port_ram.sv
`default_nettype none
// ============================================================================
// Module   : tb_sync_dual_port_ram
// Brief    : Three RAM configurations on shared stimulus, table vectors plus a
//            randomized phase against an array-based reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sync_dual_port_ram;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       wr_cs, we, rd_cs, re;
    logic [9:0] wr_addr, rd_addr;
    logic [7:0] d_in;

    always #5 clk = ~clk;

    sync_dual_port_ram_if #(.ADDR_SIZE(10), .DATA_SIZE(8)) if0 ();
    sync_dual_port_ram_if #(.ADDR_SIZE(10), .DATA_SIZE(8)) if1 ();
    sync_dual_port_ram_if #(.ADDR_SIZE(10), .DATA_SIZE(8)) if2 ();

    assign if0.wr_cs = wr_cs;   assign if1.wr_cs = wr_cs;   assign if2.wr_cs = wr_cs;
    assign if0.we = we;         assign if1.we = we;         assign if2.we = we;
    assign if0.wr_addr = wr_addr; assign if1.wr_addr = wr_addr; assign if2.wr_addr = wr_addr;
    assign if0.d_in = d_in;     assign if1.d_in = d_in;     assign if2.d_in = d_in;
    assign if0.rd_cs = rd_cs;   assign if1.rd_cs = rd_cs;   assign if2.rd_cs = rd_cs;
    assign if0.re = re;         assign if1.re = re;         assign if2.re = re;
    assign if0.rd_addr = rd_addr; assign if1.rd_addr = rd_addr; assign if2.rd_addr = rd_addr;

    sync_dual_port_ram #(.ADDR_SIZE(10), .DATA_SIZE(8), .MEM_SIZE(16), .RDW_MODE(0),
                         .CLEAR_VAL(8'hA5)) u0 (.clk(clk), .rst(rst), .bus(if0));
    sync_dual_port_ram #(.ADDR_SIZE(10), .DATA_SIZE(8), .MEM_SIZE(16), .RDW_MODE(1),
                         .CLEAR_VAL(8'h3C)) u1 (.clk(clk), .rst(rst), .bus(if1));
    sync_dual_port_ram #(.ADDR_SIZE(10), .DATA_SIZE(8), .MEM_SIZE(1000), .RDW_MODE(0),
                         .CLEAR_VAL(8'h00)) u2 (.clk(clk), .rst(rst), .bus(if2));

    logic [7:0] o_dout [3];
    logic       o_valid[3];
    logic       o_busy [3];
    logic       o_err  [3];

    assign o_dout[0] = if0.d_out;  assign o_valid[0] = if0.d_valid;
    assign o_busy[0] = if0.busy;   assign o_err[0]   = if0.addr_err;
    assign o_dout[1] = if1.d_out;  assign o_valid[1] = if1.d_valid;
    assign o_busy[1] = if1.busy;   assign o_err[1]   = if1.addr_err;
    assign o_dout[2] = if2.d_out;  assign o_valid[2] = if2.d_valid;
    assign o_busy[2] = if2.busy;   assign o_err[2]   = if2.addr_err;

    // Reference model: contents become clear_val once mem_size edges have elapsed.
    int         ms  [3];
    int         rdw [3];
    logic [7:0] cv  [3];
    logic [7:0] mm  [3][1024];
    int         mcnt[3];
    logic [7:0] mdout [3];
    logic       mvalid[3];
    logic       merr  [3];

    int n_cmp  = 0;
    int n_fail = 0;

    typedef struct {
        logic       wcs;
        logic       we;
        logic [9:0] wa;
        logic [7:0] din;
        logic       rcs;
        logic       re;
        logic [9:0] ra;
        logic [7:0] e0;
        logic [7:0] e1;
        logic       ev;
        logic       ee;
    } vec_t;

    vec_t tbl[19];

    task automatic check(input string name, input int k, input logic [31:0] act,
                         input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s dut%0d: got %0h expected %0h at %0t", name, k, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 3; k++) begin
            mdout[k] = 8'h00; mvalid[k] = 1'b0; merr[k] = 1'b0; mcnt[k] = 0;
        end
    endtask

    task automatic model_edge();
        for (int k = 0; k < 3; k++) begin
            logic wa, ra, wo, ro;
            if (mcnt[k] < ms[k]) begin
                mvalid[k] = 1'b0;
                merr[k]   = 1'b0;
                mcnt[k]++;
                if (mcnt[k] == ms[k])
                    for (int i = 0; i < ms[k]; i++) mm[k][i] = cv[k];
            end else begin
                wa = wr_cs && we;
                ra = rd_cs && re;
                wo = (int'(wr_addr) >= ms[k]);
                ro = (int'(rd_addr) >= ms[k]);
                mvalid[k] = ra;
                merr[k]   = (wa && wo) || (ra && ro);
                if (ra) begin
                    if (ro)
                        mdout[k] = 8'h00;
                    else if (rdw[k] == 1 && wa && !wo && wr_addr == rd_addr)
                        mdout[k] = d_in;
                    else
                        mdout[k] = mm[k][rd_addr];
                end
                if (wa && !wo) mm[k][wr_addr] = d_in;
            end
        end
    endtask

    task automatic check_all();
        for (int k = 0; k < 3; k++) begin
            check("d_out",    k, {24'h0, o_dout[k]}, {24'h0, mdout[k]});
            check("d_valid",  k, {31'h0, o_valid[k]}, {31'h0, mvalid[k]});
            check("busy",     k, {31'h0, o_busy[k]}, {31'h0, (mcnt[k] < ms[k])});
            check("addr_err", k, {31'h0, o_err[k]}, {31'h0, merr[k]});
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        model_edge();
        check_all();
    endtask

    task automatic idle();
        wr_cs = 1'b0; we = 1'b0; wr_addr = '0; d_in = '0;
        rd_cs = 1'b0; re = 1'b0; rd_addr = '0;
    endtask

    task automatic rand_req(input int hi);
        wr_cs   = ($urandom_range(0, 3) != 0);
        we      = ($urandom_range(0, 3) != 0);
        rd_cs   = ($urandom_range(0, 3) != 0);
        re      = ($urandom_range(0, 3) != 0);
        wr_addr = ($urandom_range(0, 7) == 0) ? 10'($urandom_range(0, 1023)) : 10'($urandom_range(0, hi));
        rd_addr = ($urandom_range(0, 7) == 0) ? 10'($urandom_range(0, 1023)) : 10'($urandom_range(0, hi));
        if ($urandom_range(0, 3) == 0) rd_addr = wr_addr;
        d_in    = 8'($urandom);
    endtask

    task automatic assert_reset();
        rst = 1'b1;
        #1;
        model_reset();
        check_all();
    endtask

    task automatic release_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // Counts busy-high edges per configuration while drive requests keep arriving.
    task automatic run_clear(input logic with_req);
        int b0, b2;
        b0 = 0; b2 = 0;
        for (int c = 0; c < 1100 && o_busy[2]; c++) begin
            if (with_req && o_busy[0]) rand_req(15); else idle();
            if (o_busy[0]) b0++;
            b2++;
            tick();
        end
        idle();
        check("clear_len_16",   0, b0, 16);
        check("clear_len_1000", 2, b2, 1000);
    endtask

    initial begin
        ms[0] = 16;   rdw[0] = 0; cv[0] = 8'hA5;
        ms[1] = 16;   rdw[1] = 1; cv[1] = 8'h3C;
        ms[2] = 1000; rdw[2] = 0; cv[2] = 8'h00;
        for (int k = 0; k < 3; k++)
            for (int i = 0; i < 1024; i++) mm[k][i] = 8'hxx;

        tbl[0]  = '{1'b1, 1'b1, 10'd1,    8'd14,  1'b0, 1'b0, 10'd0,    8'hA5, 8'h3C, 1'b0, 1'b0};
        tbl[1]  = '{1'b1, 1'b1, 10'd4,    8'd12,  1'b0, 1'b0, 10'd0,    8'hA5, 8'h3C, 1'b0, 1'b0};
        tbl[2]  = '{1'b0, 1'b0, 10'd0,    8'd0,   1'b1, 1'b1, 10'd1,    8'd14, 8'd14, 1'b1, 1'b0};
        tbl[3]  = '{1'b0, 1'b0, 10'd0,    8'd0,   1'b1, 1'b1, 10'd4,    8'd12, 8'd12, 1'b1, 1'b0};
        tbl[4]  = '{1'b0, 1'b0, 10'd0,    8'd0,   1'b1, 1'b1, 10'd4,    8'd12, 8'd12, 1'b1, 1'b0};
        tbl[5]  = '{1'b1, 1'b1, 10'd7,    8'h11,  1'b0, 1'b0, 10'd0,    8'd12, 8'd12, 1'b0, 1'b0};
        tbl[6]  = '{1'b1, 1'b1, 10'd7,    8'h22,  1'b1, 1'b1, 10'd7,    8'h11, 8'h22, 1'b1, 1'b0};
        tbl[7]  = '{1'b0, 1'b0, 10'd0,    8'd0,   1'b1, 1'b1, 10'd7,    8'h22, 8'h22, 1'b1, 1'b0};
        tbl[8]  = '{1'b1, 1'b1, 10'd9,    8'h5A,  1'b1, 1'b1, 10'd4,    8'd12, 8'd12, 1'b1, 1'b0};
        tbl[9]  = '{1'b0, 1'b0, 10'd0,    8'd0,   1'b1, 1'b1, 10'd9,    8'h5A, 8'h5A, 1'b1, 1'b0};
        tbl[10] = '{1'b0, 1'b1, 10'd9,    8'hFF,  1'b0, 1'b1, 10'd9,    8'h5A, 8'h5A, 1'b0, 1'b0};
        tbl[11] = '{1'b0, 1'b0, 10'd0,    8'd0,   1'b1, 1'b1, 10'd9,    8'h5A, 8'h5A, 1'b1, 1'b0};
        tbl[12] = '{1'b1, 1'b0, 10'd10,   8'h77,  1'b1, 1'b0, 10'd10,   8'h5A, 8'h5A, 1'b0, 1'b0};
        tbl[13] = '{1'b0, 1'b0, 10'd0,    8'd0,   1'b1, 1'b1, 10'd10,   8'hA5, 8'h3C, 1'b1, 1'b0};
        tbl[14] = '{1'b1, 1'b1, 10'd1000, 8'hEE,  1'b1, 1'b1, 10'd1023, 8'h00, 8'h00, 1'b1, 1'b1};
        tbl[15] = '{1'b0, 1'b0, 10'd0,    8'd0,   1'b1, 1'b1, 10'd8,    8'hA5, 8'h3C, 1'b1, 1'b0};
        tbl[16] = '{1'b0, 1'b0, 10'd0,    8'd0,   1'b0, 1'b0, 10'd0,    8'hA5, 8'h3C, 1'b0, 1'b0};
        tbl[17] = '{1'b1, 1'b1, 10'd15,   8'h99,  1'b1, 1'b1, 10'd16,   8'h00, 8'h00, 1'b1, 1'b1};
        tbl[18] = '{1'b0, 1'b0, 10'd0,    8'd0,   1'b1, 1'b1, 10'd15,   8'h99, 8'h99, 1'b1, 1'b0};

        idle();
        assert_reset();
        release_reset();
        run_clear(1'b1);

        for (int a = 0; a < 16; a++) begin
            rd_cs = 1'b1; re = 1'b1; rd_addr = 10'(a);
            tick();
            check("clear_rd", 0, {24'h0, o_dout[0]}, 32'hA5);
            check("clear_rd_valid", 0, {31'h0, o_valid[0]}, 32'h1);
        end
        idle();

        for (int i = 0; i < 19; i++) begin
            wr_cs = tbl[i].wcs; we = tbl[i].we; wr_addr = tbl[i].wa; d_in = tbl[i].din;
            rd_cs = tbl[i].rcs; re = tbl[i].re; rd_addr = tbl[i].ra;
            tick();
            check("tbl_dout",  0, {24'h0, o_dout[0]}, {24'h0, tbl[i].e0});
            check("tbl_dout",  1, {24'h0, o_dout[1]}, {24'h0, tbl[i].e1});
            check("tbl_valid", 0, {31'h0, o_valid[0]}, {31'h0, tbl[i].ev});
            check("tbl_err",   0, {31'h0, o_err[0]}, {31'h0, tbl[i].ee});
        end
        idle();

        // Reset in READY with a read in flight, then again five edges into CLEAR.
        rd_cs = 1'b1; re = 1'b1; rd_addr = 10'd15;
        @(posedge clk);
        #2;
        assert_reset();
        idle();
        release_reset();
        for (int c = 0; c < 5; c++) begin
            rand_req(15);
            tick();
        end
        idle();
        assert_reset();
        release_reset();
        run_clear(1'b1);

        for (int c = 0; c < 600; c++) begin
            rand_req(17);
            tick();
        end
        idle();
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/sync_dual_port_ram.md
Name: sync_dual_port_ram

Overview:
Parametrised synchronous simple-dual-port RAM that succeeds the team's asynchronous single-port RAM, with one write port and one read port sharing a single clock. Adds the following:
- registered read with a valid strobe
- selectable read-during-write behaviour
- per-port chip select
- out-of-range address detection
- a hardware clear sequencer that initialises every location after reset

It is used as the general on-chip storage block in the Memory Design library.

Parameters:
addr_size, 10, address width in bits
data_size, 8, word width in bits
mem_size, 1024, number of words; must be at most 2^addr_size
rdw_mode, 0, same-address read/write collision: 0 = read returns old data, 1 = read returns new (write-first) data
clear_val, 0, value written to every location by the clear sequencer

Ports:
clk  input  1  single clock, all state updates on rising edge
rst  input  1  asynchronous, active-high reset
wr_cs  input  1  write-port select
we  input  1  write enable; write is accepted only when wr_cs=1, we=1 and busy=0
wr_addr  input  addr_size  write address
d_in  input  data_size  write data
rd_cs  input  1  read-port select
re  input  1  read enable; read is accepted only when rd_cs=1, re=1 and busy=0
rd_addr  input  addr_size  read address
d_out  output  data_size  registered read data
d_valid  output  1  high for one cycle when d_out carries the result of an accepted read
busy  output  1  clear sequence in progress; all requests are ignored while high
addr_err  output  1  one-cycle pulse: an accepted request used an address >= mem_size

Behaviour:
- Reset (async, rst=1): d_out=0, d_valid=0, addr_err=0, busy=1, clear counter=0. Memory contents are not touched while rst is held.
- FSM has two states, CLEAR and READY. Reset forces CLEAR.
- CLEAR state:
  - On each rising edge with rst=0, write clear_val to mem[counter] and increment the counter.
  - The edge that writes location mem_size-1 moves the FSM to READY and drops busy. busy is therefore high for exactly mem_size edges after reset release.
  - Port requests during CLEAR: no memory write, d_valid=0, addr_err=0.
- READY state: the FSM stays in READY until rst is asserted.
- Write: an accepted write with wr_addr < mem_size updates mem[wr_addr] on that edge.
- Read latency is 1 cycle. An accepted read with rd_addr < mem_size samples on edge N. On edge N, d_out is loaded with mem[rd_addr] and d_valid is set to 1. Both are visible in the cycle following edge N.
- Cycles with no accepted read: d_valid=0 and d_out holds its last value.
- Same-edge write and read to the same in-range address:
  - rdw_mode=0: d_out gets the pre-write contents.
  - rdw_mode=1: d_out gets d_in.
  - In both modes the memory is updated.
- Different addresses on the same edge: the write and the read are independent and both complete.
- Out-of-range write (wr_addr >= mem_size): the write is dropped and addr_err pulses.
- Out-of-range read (rd_addr >= mem_size): d_out=0, d_valid=1 and addr_err pulses.
- If both ports are out of range on the same edge, addr_err gives a single pulse.
- Reset mid-operation, including during CLEAR:
  - All outputs return to their reset values immediately.
  - The clear sequence restarts from address 0 after release.
  - Any pending read result is discarded.
- Select low on a port (wr_cs=0 or rd_cs=0): that port has no effect on memory, d_valid or addr_err, regardless of we/re.

Test Plan:
- Reset clear: set mem_size=16 and clear_val=8'hA5, then release rst. Required: busy is high for exactly 16 edges then low. Reading addresses 0..15 afterwards returns 8'hA5 each, with d_valid one cycle after each request.
- Basic write/read: write addr 1 = 8'd14, then addr 4 = 8'd12. Read addr 1, then addr 4, then addr 4 again. Required: d_out = 14, 12, 12 on the cycle after each read, with d_valid high on each of those cycles.
- Collision: mem[7]=8'h11, then write 8'h22 to addr 7 and read addr 7 on the same edge. Required: d_out=8'h11 with rdw_mode=0 and 8'h22 with rdw_mode=1. A following read of addr 7 returns 8'h22 in both modes.
- Out of range: with mem_size=1000, write addr 1000 and read addr 1023. Required: addr_err pulses for one cycle, d_out=0 with d_valid=1, and mem contents are unchanged.
- Gating: issue requests with busy=1, then with wr_cs=0 / rd_cs=0. Required: no memory change, d_valid stays 0 and d_out holds its previous value.
- Mid-clear reset: assert rst at clear counter=5, then release. Required: busy returns to 1 and the clear sequence runs the full mem_size edges from address 0.
